// File: rtl/npu_pkg.sv
// Shared NPU weight-path constants, FSM state type and helpers.
// The flat weight-bus width is common to weight_rom, weight_loader and NPU_dotproduct.
package npu_pkg;

  localparam int unsigned WEIGHT_W    = 16;
  localparam int unsigned NUM_WEIGHTS = 64;
  localparam int unsigned NUM_BANKS   = 3;
  localparam int unsigned BANK_W      = 2;
  localparam int unsigned IDX_W       = $clog2(NUM_WEIGHTS);
  localparam int unsigned WBUS_W      = NUM_WEIGHTS * WEIGHT_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // True when a bank index addresses an existing bank.
  function automatic logic bank_in_range(input logic [BANK_W-1:0] b);
    return 32'(b) < NUM_BANKS;
  endfunction

endpackage

// File: rtl/weight_loader_if.sv
// Weight-loader port bundle: load control, weight stream, bank select and status.
// master = weight source / NPU side, slave = weight_loader.
interface weight_loader_if;
  import npu_pkg::*;

  logic                load_start;
  logic [BANK_W-1:0]   load_bank;
  logic                in_valid;
  logic                in_ready;
  logic [WEIGHT_W-1:0] in_data;
  logic                in_last;
  logic [BANK_W-1:0]   sel_bank;
  logic [WBUS_W-1:0]   weights_out;
  logic [NUM_BANKS-1:0] bank_valid;
  logic                load_busy;
  logic                load_done;
  logic                load_err;

  modport master (
    output load_start, load_bank, in_valid, in_data, in_last, sel_bank,
    input  in_ready, weights_out, bank_valid, load_busy, load_done, load_err
  );

  modport slave (
    input  load_start, load_bank, in_valid, in_data, in_last, sel_bank,
    output in_ready, weights_out, bank_valid, load_busy, load_done, load_err
  );

endinterface

// File: rtl/weight_bank.sv
// One bank of NUM_WEIGHTS weights: synchronous clear, single write port,
// whole bank visible as a flat bus (weight i at [i*WEIGHT_W +: WEIGHT_W]).
module weight_bank
  import npu_pkg::*;
(
  input  logic                clk,
  input  logic                clear,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_idx,
  input  logic [WEIGHT_W-1:0] wr_data,
  output logic [WBUS_W-1:0]   rd_bus
);

  logic [NUM_WEIGHTS-1:0][WEIGHT_W-1:0] mem_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_bus = mem_q;

endmodule

// File: rtl/weight_loader.sv
// Writable weight store: loads a 64-beat stream into one of three banks and
// presents the selected bank as a registered flat weight bus.
module weight_loader
  import npu_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  weight_loader_if.slave  bus
);

  load_state_e          state_q, state_d;
  logic [IDX_W-1:0]     count_q, count_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [NUM_BANKS-1:0] valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 ready_q;
  logic                 beat_we;
  logic                 last_idx;
  logic [WBUS_W-1:0]    weights_q, sel_bus;
  logic [NUM_BANKS-1:0][WBUS_W-1:0] rd_bus;

  assign last_idx = (count_q == IDX_W'(NUM_WEIGHTS - 1));

  // State and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      bank_q    <= '0;
      valid_q   <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      weights_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      bank_q    <= bank_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= (state_d == ST_LOAD);
      weights_q <= sel_bus;
    end
  end

  // Next-state, beat acceptance and load-protocol checking.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bank_d  = bank_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    beat_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          if (bank_in_range(bus.load_bank)) begin
            bank_d  = bus.load_bank;
            count_d = '0;
            state_d = ST_LOAD;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
              if (bus.load_bank == BANK_W'(b)) valid_d[b] = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          beat_we = 1'b1;
          count_d = IDX_W'(count_q + 1'b1);
          if (last_idx && bus.in_last) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            for (int unsigned b = 0; b < NUM_BANKS; b++) begin
              if (bank_q == BANK_W'(b)) valid_d[b] = 1'b1;
            end
          end else if (last_idx || bus.in_last) begin
            // Short or unterminated load: partial data stays, bank stays invalid.
            state_d = ST_IDLE;
            err_d   = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
    weight_bank u_bank (
      .clk     (clk),
      .clear   (reset),
      .wr_en   (beat_we && (bank_q == BANK_W'(g))),
      .wr_idx  (count_q),
      .wr_data (bus.in_data),
      .rd_bus  (rd_bus[g])
    );
  end

  // Output mux; out-of-range selects read as zero.
  always_comb begin
    sel_bus = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      if (bus.sel_bank == BANK_W'(b)) sel_bus = rd_bus[b];
    end
  end

  assign bus.in_ready    = ready_q;
  assign bus.load_busy   = ready_q;
  assign bus.load_done   = done_q;
  assign bus.load_err    = err_q;
  assign bus.bank_valid  = valid_q;
  assign bus.weights_out = weights_q;

endmodule

// File: tb/tb_weight_loader.sv
// Randomised scoreboard bench for weight_loader: a bank/valid model predicts
// load_done/load_err events and bank contents seen on weights_out.
module tb_weight_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  weight_loader_if bus_if ();

  weight_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  typedef struct {
    bit         is_done;
    logic [2:0] valid;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] model_mem [3][64];
  logic [2:0]  model_valid;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: every done/err pulse must match the next predicted event.
  always @(negedge clk) begin
    if (!reset && (bus_if.load_done || bus_if.load_err)) begin
      ev_t e;
      if (bus_if.load_done && bus_if.load_err) begin
        chk("done_err_overlap", 32'd1, 32'd0);
      end else if (exp_q.size() == 0) begin
        chk("unexpected_event", {31'd0, bus_if.load_done}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("event_kind_done", {31'd0, bus_if.load_done}, {31'd0, e.is_done});
        chk("event_bank_valid", {29'd0, bus_if.bank_valid}, {29'd0, e.valid});
      end
    end
  end

  task automatic check_bank(input int b);
    int bad;
    logic [15:0] got, exp;
    @(negedge clk);
    bus_if.sel_bank = 2'(b);
    @(negedge clk);
    bad = -1;
    for (int i = 0; i < 64; i++) begin
      got = bus_if.weights_out[i*16 +: 16];
      exp = (b < 3) ? model_mem[b][i] : 16'h0;
      if (got !== exp && bad < 0) bad = i;
    end
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL weights_bank%0d word %0d got=%0h exp=%0h", b, bad,
               bus_if.weights_out[bad*16 +: 16], (b < 3) ? model_mem[b][bad] : 16'h0);
    end
  endtask

  // last_at: beat index carrying in_last (64 = never). mode: 0 full rate,
  // 1 drop every third cycle, 2 random. pat: 0 index, 1 0xAAAA, 2 random.
  task automatic do_load(input int bank, input int last_at, input int mode,
                         input int pat, input bit mid_start);
    int k, i, cyc;
    bit ok, v;
    logic [15:0] d;
    ev_t e;
    k  = (last_at < 63) ? last_at : 63;
    ok = (last_at == 63);
    model_valid[bank] = ok;
    e.is_done = ok;
    e.valid   = model_valid;
    exp_q.push_back(e);
    @(negedge clk);
    bus_if.load_start = 1'b1;
    bus_if.load_bank  = 2'(bank);
    @(negedge clk);
    bus_if.load_start = 1'b0;
    chk("ready_busy_after_start", {30'd0, bus_if.in_ready, bus_if.load_busy}, 32'd3);
    i = 0;
    cyc = 0;
    while (i <= k && cyc < 2000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 3) != 2;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      case (pat)
        0:       d = 16'(i);
        1:       d = 16'hAAAA;
        default: d = 16'($urandom);
      endcase
      bus_if.in_valid = v;
      bus_if.in_data  = d;
      bus_if.in_last  = (i == last_at);
      if (mid_start && i == 20) begin
        bus_if.load_start = 1'b1;
        bus_if.load_bank  = 2'd1;
      end else begin
        bus_if.load_start = 1'b0;
      end
      if (v && bus_if.in_ready) begin
        model_mem[bank][i] = d;
        i++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 2000) chk("load_timeout", 32'd1, 32'd0);
    bus_if.in_valid   = 1'b0;
    bus_if.in_last    = 1'b0;
    bus_if.load_start = 1'b0;
    chk("ready_low_after_load", {31'd0, bus_if.in_ready}, 32'd0);
    @(negedge clk);
  endtask

  task automatic bad_bank_start();
    ev_t e;
    e.is_done = 1'b0;
    e.valid   = model_valid;
    exp_q.push_back(e);
    @(negedge clk);
    bus_if.load_start = 1'b1;
    bus_if.load_bank  = 2'd3;
    @(negedge clk);
    bus_if.load_start = 1'b0;
    @(negedge clk);
    chk("bad_bank_stays_idle", {30'd0, bus_if.in_ready, bus_if.load_busy}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, la;
    bus_if.load_start = 1'b0;
    bus_if.load_bank  = '0;
    bus_if.in_valid   = 1'b0;
    bus_if.in_data    = '0;
    bus_if.in_last    = 1'b0;
    bus_if.sel_bank   = '0;
    model_valid = '0;
    for (int b = 0; b < 3; b++) for (int i = 0; i < 64; i++) model_mem[b][i] = 16'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("reset_ready", {31'd0, bus_if.in_ready}, 32'd0);
    chk("reset_busy", {31'd0, bus_if.load_busy}, 32'd0);
    chk("reset_bank_valid", {29'd0, bus_if.bank_valid}, 32'd0);
    chk("reset_done_err", {30'd0, bus_if.load_done, bus_if.load_err}, 32'd0);
    check_bank(0);

    do_load(0, 63, 0, 0, 1'b0);
    check_bank(0);
    chk("bank0_word0", {16'd0, bus_if.weights_out[15:0]}, 32'h0000);
    chk("bank0_word63", {16'd0, bus_if.weights_out[1023:1008]}, 32'h003F);

    do_load(2, 63, 1, 1, 1'b0);
    check_bank(2);
    check_bank(0);
    check_bank(1);

    do_load(1, 10, 2, 2, 1'b0);
    chk("short_ready_busy", {30'd0, bus_if.in_ready, bus_if.load_busy}, 32'd0);
    check_bank(1);

    do_load(1, 64, 2, 2, 1'b0);
    chk("unterminated_valid", {29'd0, bus_if.bank_valid}, {29'd0, model_valid});
    bad_bank_start();
    check_bank(3);

    do_load(0, 63, 2, 2, 1'b1);
    check_bank(0);
    check_bank(1);

    for (int n = 0; n < 6; n++) begin
      r = $urandom_range(0, 3);
      la = (r == 0) ? int'($urandom_range(0, 62)) : (r == 1) ? 64 : 63;
      do_load(int'($urandom_range(0, 2)), la, 2, 2, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) bad_bank_start();
      check_bank(int'($urandom_range(0, 3)));
    end
    for (int b = 0; b < 3; b++) check_bank(b);

    // Reset 30 beats into a load of bank 0.
    @(negedge clk);
    bus_if.load_start = 1'b1;
    bus_if.load_bank  = 2'd0;
    @(negedge clk);
    bus_if.load_start = 1'b0;
    bus_if.in_valid   = 1'b1;
    for (int i = 0; i < 30; i++) begin
      bus_if.in_data = 16'($urandom);
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_ready", {31'd0, bus_if.in_ready}, 32'd0);
    chk("midreset_valid", {29'd0, bus_if.bank_valid}, 32'd0);
    chk("midreset_weights", {31'd0, |bus_if.weights_out}, 32'd0);
    reset = 1'b0;
    model_valid = '0;
    for (int b = 0; b < 3; b++) for (int i = 0; i < 64; i++) model_mem[b][i] = 16'h0;
    for (int b = 0; b < 4; b++) check_bank(b);

    do_load(2, 63, 2, 2, 1'b0);
    check_bank(2);
    repeat (4) @(negedge clk);
    chk("events_outstanding", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
